// File: rtl/dsp_pkg.sv
// Shared types and defaults for the DSP operand loader slice.
package dsp_pkg;

  localparam int unsigned OPERAND_W = 18;
  localparam int unsigned BEAT_W    = 6;

  typedef enum logic [0:0] {
    StCollect,
    StEmit
  } state_e;

  // Ceiling log2, floored at 1 so a counter is never zero bits wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    if (res == 0) begin
      res = 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp_beat_packer.sv
// Beat packing buffer and beat counter: beat k lands in bits [k*W +: W], LSB-first.
module dsp_beat_packer
  import dsp_pkg::*;
#(
  parameter int unsigned N = OPERAND_W,
  parameter int unsigned W = BEAT_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        accept_i,  // beat handshake completes this cycle
  input  logic                        end_i,     // accepted beat closes or aborts the word
  input  logic [W-1:0]                data_i,
  output logic [clog2(N/W)-1:0]       cnt_o,
  output logic                        last_o,    // next beat is the final slot
  output logic [N-1:0]                word_o     // buffer with the current beat merged in
);

  localparam int unsigned Beats = N / W;
  localparam int unsigned CntW  = clog2(Beats);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    buf_q, buf_d;

  // Merge the incoming beat at the slot selected by the count.
  always_comb begin
    word_o = buf_q;
    for (int k = 0; k < Beats; k++) begin
      if (cnt_q == CntW'(k)) begin
        word_o[k*W +: W] = data_i;
      end
    end
  end

  // Advance or clear the buffer; a closed word leaves the buffer zeroed.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (accept_i) begin
      if (end_i) begin
        buf_d = '0;
        cnt_d = '0;
      end else begin
        buf_d = word_o;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Buffer and counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CntW'(Beats - 1));

endmodule

// File: rtl/dsp_operand_loader.sv
// Assembles W-bit beats into N-bit operand words and strobes them into the
// downstream operand register. Optional even-parity checking on each beat is
// enabled by defining DSP_OPERAND_LOADER_PARITY_EN (adds the in_par input).
module dsp_operand_loader
  import dsp_pkg::*;
#(
  parameter int unsigned N = OPERAND_W,
  parameter int unsigned W = BEAT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
`ifdef DSP_OPERAND_LOADER_PARITY_EN
  input  logic         in_par,
`endif
  output logic         in_ready,
  output logic [N-1:0] out_word,
  output logic         out_en,
  output logic         busy,
  output logic         err
);

  localparam int unsigned Beats = N / W;
  localparam int unsigned CntW  = clog2(Beats);

  if ((W == 0) || (N % W != 0) || (N / W < 2)) begin : g_bad_params
    $fatal(1, "dsp_operand_loader: N must be a multiple of W with at least 2 beats");
  end

  state_e          state_q, state_d;
  logic [N-1:0]    out_word_q, out_word_d;
  logic            err_q, err_d;
  logic            ready_q, ready_d;
  logic            accept, word_end, good, bad_word;
  logic            pk_last;
  logic [CntW-1:0] pk_cnt;
  logic [N-1:0]    pk_word;

  assign accept   = in_valid & ready_q;
  assign word_end = accept & (in_last | pk_last);

`ifdef DSP_OPERAND_LOADER_PARITY_EN
  logic bad_q, bad_d, beat_bad;

  // Even parity: in_par plus the data bits must have an even population.
  assign beat_bad = in_par ^ (^in_data);
  assign bad_word = bad_q | beat_bad;

  // Sticky per-word parity fault, dropped whenever the word ends.
  always_comb begin
    bad_d = bad_q;
    if (word_end) begin
      bad_d = 1'b0;
    end else if (accept && beat_bad) begin
      bad_d = 1'b1;
    end
  end

  // Parity fault flag register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bad_q <= 1'b0;
    end else begin
      bad_q <= bad_d;
    end
  end
`else
  assign bad_word = 1'b0;
`endif

  // Only a correctly framed, clean word reaches the final slot with in_last set.
  assign good = accept & in_last & pk_last & ~bad_word;

  dsp_beat_packer #(
    .N (N),
    .W (W)
  ) u_packer (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .accept_i (accept),
    .end_i    (word_end),
    .data_i   (in_data),
    .cnt_o    (pk_cnt),
    .last_o   (pk_last),
    .word_o   (pk_word)
  );

  // Next state, output word, error pulse and ready.
  always_comb begin
    state_d    = state_q;
    out_word_d = out_word_q;
    err_d      = word_end & ~good;
    unique case (state_q)
      StCollect: begin
        if (good) begin
          state_d    = StEmit;
          out_word_d = pk_word;
        end
      end
      StEmit: begin
        state_d = StCollect;
      end
      default: begin
        state_d = StCollect;
      end
    endcase
    // Registered so in_ready stays low until the first edge after reset.
    ready_d = (state_d == StCollect);
  end

  // FSM and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StCollect;
      out_word_q <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      out_word_q <= out_word_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready = ready_q;
  assign out_word = out_word_q;
  assign out_en   = (state_q == StEmit);
  assign err      = err_q;
  assign busy     = (pk_cnt != '0);

endmodule

// File: doc/dsp_operand_loader.md
Name: dsp_operand_loader

Overview:
- Producer side of the operand pipeline registers: it generates the N-bit D word and the one-cycle En load strobe that the synchronous/asynchronous operand registers capture.
- Accepts a framed, narrow beat stream (W bits per beat) over a valid/ready handshake and assembles N-bit words LSB-first.
- Emits one load pulse per correctly framed word and flags framing errors.
- Sits between the host/stream interface and the DSP slice operand registers (A/B/D/C inputs).

Parameters:
- N, 18, operand word width; must equal the width of the downstream operand register.
- W, 6, beat width; N must be an integer multiple of W (elaboration-time check, fatal on violation).
- BEATS (localparam), N/W, beats per word; BEATS >= 2 required.

Ports:
- CLK  input  1  clock, all state rising-edge.
- RST  input  1  reset, asynchronous assert, active-low (0 = reset); synchronous deassert is the system's responsibility.
- in_data  input  W  beat payload.
- in_valid  input  1  beat present.
- in_last  input  1  marks final beat of a word; qualified by in_valid.
- in_ready  output  1  loader can accept a beat.
- out_word  output  N  assembled word; drives downstream register D.
- out_en  output  1  one-cycle load strobe; drives downstream register En.
- busy  output  1  partial word held (beat count != 0).
- err  output  1  one-cycle framing-error pulse.

Behaviour:
- Beat accepted on a rising CLK edge when in_valid && in_ready.
- Reset (RST=0, asynchronous): state=COLLECT, cnt=0, shift buffer=0, out_word=0, out_en=0, err=0, in_ready=0 while in reset.
- Reset mid-word discards the partial word; no out_en is produced for it.
- States:
  - COLLECT: in_ready=1.
  - EMIT: exactly one cycle; in_ready=0, out_en=1; then always returns to COLLECT.
- Beat counter cnt runs 0..BEATS-1 and indexes the packing: beat k lands in bits [k*W+W-1 : k*W]. Bits not yet written in the current word read 0 in the buffer.
- Accepted beat with cnt<BEATS-1 and in_last=0: store the beat, cnt++.
- Accepted beat with cnt==BEATS-1 and in_last=1: store the beat, load out_word with the full word, cnt=0, go to EMIT.
- Latency: out_en is high in the cycle immediately after the final beat is accepted. out_word is valid in that same cycle and holds until the next EMIT.
- Early last (in_last=1 with cnt<BEATS-1):
  - err=1 next cycle; word discarded; cnt=0; buffer cleared; out_word unchanged.
  - Stays in COLLECT; no out_en.
- Missing last (cnt==BEATS-1, in_last=0):
  - err=1 next cycle; word discarded; cnt=0; no out_en.
- in_valid during EMIT: not accepted because in_ready=0. The source must hold the beat stable. Maximum sustained throughput is BEATS beats per BEATS+1 cycles.
- err and out_en are never high in the same cycle.
- busy = (cnt != 0); combinational from the registered count.
- in_data and in_last are don't-care when in_valid=0.

Optional Feature:
- Macro: DSP_OPERAND_LOADER_PARITY_EN.
- Defined:
  - Adds input in_par (1 bit): even parity over in_data, qualified with the beat.
  - A mismatch on any beat sets a per-word bad flag (cleared when the word completes or is discarded).
  - At the final beat, a bad word is discarded exactly like a framing error: err pulse, no out_en.
- Undefined: no in_par port and no parity logic; behaviour is exactly as above.

Decomposition:
- Shared package dsp_pkg holds:
  - State enum (COLLECT, EMIT).
  - Default widths OPERAND_W=18 and BEAT_W=6.
  - Function clog2 for sizing cnt ($clog2(BEATS)).
- One natural sub-module: dsp_beat_packer, which owns the shift/packing buffer and beat counter. The top level holds the FSM, error and strobe logic.

Test Plan:
- Reset then 3 beats 0x01, 0x02, 0x03 (last on 3rd), back-to-back → out_word=0x03081 and out_en=1 the cycle after beat 3; in_ready=0 during that cycle; err=0.
- Continuous valid across two words (0x3F×3, then 0x00,0x15,0x2A) → out_word=0x3FFFF, then 0x2A540; in_ready drops for exactly one cycle per word.
- Early last: beats 0x05, 0x07 with last on beat 2 → err pulse next cycle, no out_en; a following good word loads correctly.
- Missing last: 3 beats with in_last=0 → err pulse, no out_en, busy=0 afterwards.
- Assert RST=0 asynchronously after 2 beats, mid-cycle → outputs clear immediately without a clock edge; a subsequent 3-beat word emits normally.
- With DSP_OPERAND_LOADER_PARITY_EN defined, wrong in_par on beat 2 → err, no out_en; correct parity → normal load.
